// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and word-select decode.
package i2s_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned CNT_W      = 6;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // ws switches one bit before the slot MSB, so the right half spans c = 31..62.
  function automatic logic ws_for(logic [CNT_W-1:0] c);
    return (c >= CNT_W'(31) && c <= CNT_W'(62)) ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/i2s_transmit_if.sv
// Upstream sample-pair handshake between a producer and the I2S transmitter.
interface i2s_transmit_if #(
  parameter int unsigned SAMPLE_W = 32
);

  logic [SAMPLE_W-1:0] data_left;
  logic [SAMPLE_W-1:0] data_right;
  logic                valid;
  logic                ready;

  modport master (output data_left, output data_right, output valid, input ready);
  modport slave  (input data_left, input data_right, input valid, output ready);

endinterface

// File: rtl/i2s_tx_hold.sv
// Single-entry holding register for the I2S transmitter; owns the valid/ready handshake.
module i2s_tx_hold #(
  parameter int unsigned SAMPLE_W = 32
) (
  input  logic                sck,
  input  logic                rst,
  i2s_transmit_if.slave       bus,
  input  logic                load,
  output logic                full,
  output logic [SAMPLE_W-1:0] hold_left,
  output logic [SAMPLE_W-1:0] hold_right
);

  logic                full_q;
  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] right_q;

  // A load only drains a full register; an empty register may still capture on the load cycle.
  always_ff @(negedge sck or negedge rst) begin
    if (!rst) begin
      full_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else if (load && full_q) begin
      full_q <= 1'b0;
    end else if (bus.valid && !full_q) begin
      full_q  <= 1'b1;
      left_q  <= bus.data_left;
      right_q <= bus.data_right;
    end
  end

  assign bus.ready  = ~full_q;
  assign full       = full_q;
  assign hold_left  = left_q;
  assign hold_right = right_q;

endmodule

// File: rtl/i2s_transmit.sv
// I2S transmitter: 64-bit frame, state on falling sck, MSB-first left-justified slots.
// Build option I2S_TRANSMIT_REPEAT_EN: underrun frames resend the last pair instead of zeros.
module i2s_transmit
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 32
) (
  input  logic          sck,
  input  logic          rst,
  i2s_transmit_if.slave bus,
  output logic          ws,
  output logic          sd,
  output logic          underrun
);

  logic [CNT_W-1:0]      c_q;
  logic                  ws_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [FRAME_BITS-1:0] reload;
  logic [FRAME_BITS-1:0] idle_frame;
  logic [SLOT_BITS-1:0]  left_slot;
  logic [SLOT_BITS-1:0]  right_slot;
  logic [SAMPLE_W-1:0]   hold_left;
  logic [SAMPLE_W-1:0]   hold_right;
  logic                  full;
  logic                  frame_end;

  assign frame_end = (c_q == CNT_W'(FRAME_BITS - 1));

  i2s_tx_hold #(
    .SAMPLE_W (SAMPLE_W)
  ) u_hold (
    .sck        (sck),
    .rst        (rst),
    .bus        (bus),
    .load       (frame_end),
    .full       (full),
    .hold_left  (hold_left),
    .hold_right (hold_right)
  );

`ifdef I2S_TRANSMIT_REPEAT_EN
  logic [FRAME_BITS-1:0] last_q;

  always_ff @(negedge sck or negedge rst) begin
    if (!rst) begin
      last_q <= '0;
    end else if (frame_end && full) begin
      last_q <= {left_slot, right_slot};
    end
  end

  assign idle_frame = last_q;
`else
  assign idle_frame = '0;
`endif

  always_comb begin
    left_slot  = SLOT_BITS'(hold_left) << (SLOT_BITS - SAMPLE_W);
    right_slot = SLOT_BITS'(hold_right) << (SLOT_BITS - SAMPLE_W);
    reload     = full ? {left_slot, right_slot} : idle_frame;
  end

  // frame_q[63] is the bit on the wire; the whole frame shifts out MSB first.
  always_ff @(negedge sck or negedge rst) begin
    if (!rst) begin
      c_q     <= '0;
      ws_q    <= LEFT;
      frame_q <= '0;
    end else begin
      c_q     <= c_q + CNT_W'(1);
      ws_q    <= ws_for(c_q + CNT_W'(1));
      frame_q <= frame_end ? reload : (frame_q << 1);
    end
  end

  assign ws       = ws_q;
  assign sd       = frame_q[FRAME_BITS-1];
  assign underrun = frame_end & ~full;

endmodule

// File: tb/tb_i2s_transmit.sv
// Directed bench for i2s_transmit with a frame-level reference model and per-cycle compare.
module tb_i2s_transmit;

  logic sck = 1'b1;
  logic rst = 1'b0;
  always #5 sck = ~sck;

  i2s_transmit_if #(.SAMPLE_W(32)) bus ();
  i2s_transmit_if #(.SAMPLE_W(24)) bus2 ();

  logic ws, sd, underrun;
  logic ws2, sd2, underrun2;

  i2s_transmit #(.SAMPLE_W(32)) dut (
    .sck      (sck),
    .rst      (rst),
    .bus      (bus),
    .ws       (ws),
    .sd       (sd),
    .underrun (underrun)
  );

  i2s_transmit #(.SAMPLE_W(24)) dut24 (
    .sck      (sck),
    .rst      (rst),
    .bus      (bus2),
    .ws       (ws2),
    .sd       (sd2),
    .underrun (underrun2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: the pair on the wire this frame, pending accepted pairs, last pair sent.
  int          mc = 0;
  logic [63:0] cur_word = '0;
  logic [63:0] last_word = '0;
  logic [63:0] pending[$];

  always @(negedge sck or negedge rst) begin
    if (!rst) begin
      mc = 0;
      cur_word = '0;
      last_word = '0;
      pending.delete();
    end else begin
      bit accept;
      accept = bus.valid && (pending.size() == 0);
      if (mc == 63) begin
        if (pending.size() != 0) begin
          cur_word = pending.pop_front();
          last_word = cur_word;
        end else begin
`ifdef I2S_TRANSMIT_REPEAT_EN
          cur_word = last_word;
`else
          cur_word = '0;
`endif
        end
      end
      if (accept) pending.push_back({bus.data_left, bus.data_right});
      mc = (mc + 1) % 64;
    end
  end

  always @(posedge sck) begin
    if (rst) begin
      check($sformatf("ws c=%0d", mc), 64'(ws), 64'(mc >= 31 && mc <= 62));
      check($sformatf("sd c=%0d", mc), 64'(sd), 64'(cur_word[63 - mc]));
      check($sformatf("ready c=%0d", mc), 64'(bus.ready), 64'(pending.size() == 0));
      check($sformatf("underrun c=%0d", mc), 64'(underrun),
            64'(mc == 63 && pending.size() == 0));
    end
  end

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic wait_c(input int k);
    int n = 0;
    while (mc != k && n < 200) begin
      tick();
      n++;
    end
    if (mc != k) check("wait_c timeout", 64'(mc), 64'(k));
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r);
    int n = 0;
    bus.data_left = l;
    bus.data_right = r;
    bus.valid = 1'b1;
    while (!bus.ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.ready) check("send timeout", 64'(bus.ready), 64'd1);
    tick();
    bus.valid = 1'b0;
  endtask

  task automatic capture(output logic [63:0] w, output logic [63:0] w2);
    for (int i = 0; i < 64; i++) begin
      w[63 - i] = sd;
      w2[63 - i] = sd2;
      tick();
    end
  endtask

  logic [63:0] word, word2, exp3;
  logic        ws30, ws31;
  int          n_und, n_acc;
  logic [31:0] k;

  initial begin
    bus.valid = 1'b0;
    bus.data_left = '0;
    bus.data_right = '0;
    bus2.valid = 1'b0;
    bus2.data_left = '0;
    bus2.data_right = '0;

    // Reset state
    tick();
    check("reset ws", 64'(ws), 64'd0);
    check("reset sd", 64'(sd), 64'd0);
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset underrun", 64'(underrun), 64'd0);
    tick();
    rst = 1'b1;

    // Pair accepted during frame 1 appears in frame 2; 24-bit instance left-justifies.
    bus.data_left = 32'h8000_0001;
    bus.data_right = 32'h7FFF_FFFE;
    bus.valid = 1'b1;
    bus2.data_left = 24'hABCDEF;
    bus2.data_right = 24'h123456;
    bus2.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    bus2.valid = 1'b0;
    wait_c(0);
    ws30 = 1'b0;
    ws31 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      word[63 - i] = sd;
      word2[63 - i] = sd2;
      if (i == 30) ws30 = ws;
      if (i == 31) ws31 = ws;
      tick();
    end
    check("frame2 pair", word, 64'h8000_0001_7FFF_FFFE);
    check("ws before right MSB", 64'(ws30), 64'd0);
    check("ws at right MSB-1", 64'(ws31), 64'd1);
    check("24-bit slots", word2, 64'hABCD_EF00_1234_5600);

    // Idle: one underrun per frame, zeros or repeated pair
    n_und = 0;
    for (int i = 0; i < 192; i++) begin
      if (i < 64) word[63 - i] = sd;
      if (underrun) n_und++;
      tick();
    end
`ifdef I2S_TRANSMIT_REPEAT_EN
    exp3 = 64'h8000_0001_7FFF_FFFE;
`else
    exp3 = 64'd0;
`endif
    check("idle underrun count", 64'(n_und), 64'd3);
    check("idle frame data", word, exp3);

    // Continuous valid: one accept per frame, no underrun
    n_acc = 0;
    n_und = 0;
    k = 32'h100;
    bus.valid = 1'b1;
    for (int i = 0; i < 384; i++) begin
      bit acc;
      bus.data_left = k;
      bus.data_right = k ^ 32'hFFFF_0000;
      acc = bus.ready;
      if (underrun) n_und++;
      tick();
      if (acc) begin
        n_acc++;
        k++;
      end
    end
    bus.valid = 1'b0;
    check("stream accepts", 64'(n_acc), 64'd6);
    check("stream underruns", 64'(n_und), 64'd0);

    // valid rising at c=63 with empty register: underrun now, pair in frame after next
    wait_c(63);
    wait_c(63);
    bus.data_left = 32'hC0FF_EE01;
    bus.data_right = 32'h0123_4567;
    bus.valid = 1'b1;
    check("late valid underrun", 64'(underrun), 64'd1);
    tick();
    bus.valid = 1'b0;
    repeat (64) tick();
    capture(word, word2);
    check("late pair frame", word, 64'hC0FF_EE01_0123_4567);

    // Reset mid-frame discards held data and restarts framing
    send(32'hDEAD_BEEF, 32'h0BAD_F00D);
    wait_c(40);
    rst = 1'b0;
    #1;
    check("midreset ws", 64'(ws), 64'd0);
    check("midreset sd", 64'(sd), 64'd0);
    check("midreset ready", 64'(bus.ready), 64'd1);
    check("midreset underrun", 64'(underrun), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    capture(word, word2);
    check("post-reset frame", word, 64'd0);
    send(32'h1357_9BDF, 32'h2468_ACE0);
    wait_c(0);
    capture(word, word2);
    check("loopback pair", word, 64'h1357_9BDF_2468_ACE0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
